// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular exponentiation engine.
package rsa_pkg;

   // Exponentiation sequencer states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MUL,
      ST_NEXT,
      ST_OUT
   } state_t;

   localparam int DEFAULT_WIDTH = 32;

   // Accumulator width for the default word size: holds 2P + a before reduction
   localparam int ACC_W = DEFAULT_WIDTH + 2;

   // Accumulator width for an arbitrary word size
   function automatic int acc_width(input int width);
      return width + 2;
   endfunction

endpackage

// File: rtl/rsa_modexp_engine_mod_mult.sv
// Interleaved shift-add modular multiplier: p = a * b mod n.
// Scans b MSB first, one bit per cycle. The first bit is folded into the
// start cycle, so done pulses exactly WIDTH cycles after start.
module mod_mult
   import rsa_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic             done,
   output logic [WIDTH-1:0] p
);

   localparam int ACC_BITS = acc_width(WIDTH);
   localparam int CNT_W    = $clog2(WIDTH);

   logic [WIDTH-1:0]    a_q;
   logic [WIDTH-1:0]    n_q;
   logic [WIDTH-1:0]    b_q;
   logic [WIDTH-1:0]    p_q;
   logic [CNT_W-1:0]    cnt;
   logic                active;
   logic                done_q;

   logic [WIDTH-1:0]    step_p;
   logic [WIDTH-1:0]    step_a;
   logic [WIDTH-1:0]    step_n;
   logic                step_bit;
   logic [ACC_BITS-1:0] n_ext;
   logic [ACC_BITS-1:0] acc_dbl;
   logic [ACC_BITS-1:0] acc_sum;
   logic                unused_acc_hi;

   // One multiplier step; on the start cycle it works from the live inputs
   always_comb begin
      step_p   = active ? p_q : '0;
      step_a   = active ? a_q : a;
      step_n   = active ? n_q : n;
      step_bit = active ? b_q[WIDTH-1] : b[WIDTH-1];
      n_ext    = {2'b00, step_n};
      acc_dbl  = {1'b0, step_p, 1'b0};
      if (acc_dbl >= n_ext) begin
         acc_dbl = acc_dbl - n_ext;
      end
      acc_sum = acc_dbl;
      if (step_bit) begin
         acc_sum = acc_dbl + {2'b00, step_a};
         if (acc_sum >= n_ext) begin
            acc_sum = acc_sum - n_ext;
         end
      end
   end

   // After reduction the result is always below n, so the top bits are zero
   assign unused_acc_hi = ^acc_sum[ACC_BITS-1:WIDTH];

   // Operand capture, bit-serial accumulation and terminal-count done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         n_q    <= '0;
         b_q    <= '0;
         p_q    <= '0;
         cnt    <= '0;
         active <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            a_q    <= a;
            n_q    <= n;
            b_q    <= {b[WIDTH-2:0], 1'b0};
            p_q    <= acc_sum[WIDTH-1:0];
            cnt    <= CNT_W'(WIDTH - 1);
            active <= 1'b1;
         end else if (active) begin
            p_q <= acc_sum[WIDTH-1:0];
            b_q <= {b_q[WIDTH-2:0], 1'b0};
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               active <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done = done_q;
   assign p    = p_q;

endmodule

// File: rtl/rsa_modexp_engine.sv
// RSA engine: out_data = in_data ^ (mode ? d : e) mod n, right-to-left
// square-and-multiply with two parallel interleaved modular multipliers.
//
// state | meaning
// IDLE  | waiting for a message word (in_ready when keys are valid)
// LOAD  | r = 1, exponent selected from e or d
// MUL   | r*(exp[0] ? a : 1) and a*a running in parallel
// NEXT  | store products, shift exponent right
// OUT   | result presented until out_ready
module rsa_modexp_engine
   import rsa_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int LEN_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_load,
   input  logic [WIDTH-1:0] n_key,
   input  logic [WIDTH-1:0] e_key,
   input  logic [WIDTH-1:0] d_key,
   input  logic             mode,
   output logic             key_ready,
   output logic [LEN_W-1:0] n_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             err
);

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] n_reg;
   logic [WIDTH-1:0] e_reg;
   logic [WIDTH-1:0] d_reg;
   logic             key_ready_q;
   logic [LEN_W-1:0] len_q;
   logic [WIDTH-1:0] n_shift;
   logic [LEN_W-1:0] scan_cnt;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] exp_reg;
   logic             mode_q;
   logic             err_q;
   logic             mul_start;

   logic             key_accept;
   logic             in_hs;
   logic             in_bad;
   logic             in_ok;
   logic [WIDTH-1:0] exp_sel;
   logic [WIDTH-1:0] mult_b;
   logic             done_r;
   logic             done_a;
   logic [WIDTH-1:0] p_r;
   logic [WIDTH-1:0] p_a;

   // A key load always wins over a simultaneous message in IDLE
   assign key_accept = key_load && (state == ST_IDLE);
   assign in_ready   = (state == ST_IDLE) && key_ready_q && !key_load;
   assign in_hs      = in_valid && in_ready;
   assign in_bad     = (in_data >= n_reg) || (n_reg < WIDTH'(2));
   assign in_ok      = in_hs && !in_bad;
   assign exp_sel    = mode_q ? d_reg : e_reg;
   assign mult_b     = exp_reg[0] ? a_reg : WIDTH'(1);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and status outputs
   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (in_ok) begin
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_nxt = (exp_sel == '0) ? ST_OUT : ST_MUL;
         end
         ST_MUL: begin
            if (done_r && done_a) begin
               state_nxt = ST_NEXT;
            end
         end
         ST_NEXT: begin
            state_nxt = (exp_reg[WIDTH-1:1] == '0) ? ST_OUT : ST_MUL;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Key capture and bit-length measurement: WIDTH shift cycles counting
   // while the shifted copy of n is still nonzero
   always_ff @(posedge clk) begin
      if (rst) begin
         n_reg       <= '0;
         e_reg       <= '0;
         d_reg       <= '0;
         key_ready_q <= 1'b0;
         len_q       <= '0;
         n_shift     <= '0;
         scan_cnt    <= '0;
      end else if (key_accept) begin
         n_reg       <= n_key;
         e_reg       <= e_key;
         d_reg       <= d_key;
         key_ready_q <= 1'b0;
         len_q       <= '0;
         n_shift     <= n_key;
         scan_cnt    <= LEN_W'(WIDTH);
      end else if (scan_cnt != '0) begin
         if (n_shift != '0) begin
            len_q <= len_q + LEN_W'(1);
         end
         n_shift  <= {1'b0, n_shift[WIDTH-1:1]};
         scan_cnt <= scan_cnt - LEN_W'(1);
         if (scan_cnt == LEN_W'(1)) begin
            key_ready_q <= 1'b1;
         end
      end
   end

   // Exponentiation datapath, error pulse and multiplier start strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg     <= '0;
         r_reg     <= '0;
         exp_reg   <= '0;
         mode_q    <= 1'b0;
         err_q     <= 1'b0;
         mul_start <= 1'b0;
      end else begin
         err_q     <= in_hs && in_bad;
         mul_start <= (state_nxt == ST_MUL) && (state != ST_MUL);
         if (in_ok) begin
            a_reg  <= in_data;
            mode_q <= mode;
         end
         case (state)
            ST_LOAD: begin
               r_reg   <= WIDTH'(1);
               exp_reg <= exp_sel;
            end
            ST_NEXT: begin
               r_reg   <= p_r;
               a_reg   <= p_a;
               exp_reg <= {1'b0, exp_reg[WIDTH-1:1]};
            end
            default: begin
            end
         endcase
      end
   end

   mod_mult #(.WIDTH(WIDTH)) u_mult_r (
      .clk   (clk),
      .rst   (rst),
      .start (mul_start),
      .a     (r_reg),
      .b     (mult_b),
      .n     (n_reg),
      .done  (done_r),
      .p     (p_r)
   );

   mod_mult #(.WIDTH(WIDTH)) u_mult_a (
      .clk   (clk),
      .rst   (rst),
      .start (mul_start),
      .a     (a_reg),
      .b     (a_reg),
      .n     (n_reg),
      .done  (done_a),
      .p     (p_a)
   );

   assign key_ready = key_ready_q;
   assign n_len     = len_q;
   assign out_data  = r_reg;
   assign err       = err_q;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Self-checking bench for rsa_modexp_engine with an expected-result queue.
module tb_rsa_modexp_engine;

   localparam int W  = 32;
   localparam int LW = $clog2(W + 1);

   logic          clk;
   logic          rst;
   logic          key_load;
   logic [W-1:0]  n_key;
   logic [W-1:0]  e_key;
   logic [W-1:0]  d_key;
   logic          mode;
   logic          key_ready;
   logic [LW-1:0] n_len;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          busy;
   logic          err;

   rsa_modexp_engine #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_load  (key_load),
      .n_key     (n_key),
      .e_key     (e_key),
      .d_key     (d_key),
      .mode      (mode),
      .key_ready (key_ready),
      .n_len     (n_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];
   int hs_cyc;
   logic [W-1:0] k_n, k_e, k_d;

   function automatic logic [W-1:0] modpow(input logic [W-1:0] b, input logic [W-1:0] e,
                                           input logic [W-1:0] n);
      longint unsigned r, x, nn;
      logic [W-1:0] ee;
      nn = 64'(n);
      r  = 1;
      x  = 64'(b) % nn;
      ee = e;
      while (ee != 0) begin
         if (ee[0]) r = (r * x) % nn;
         x  = (x * x) % nn;
         ee = ee >> 1;
      end
      return r[W-1:0];
   endfunction

   function automatic int bitlen(input logic [W-1:0] v);
      int l = 0;
      for (int i = 0; i < W; i++) if (v[i]) l = i + 1;
      return l;
   endfunction

   function automatic int lat_for(input logic [W-1:0] e);
      return 2 + bitlen(e) * (W + 2);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      n_checks++;
      if (key_ready !== 1'b0 || n_len !== '0 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
          out_data !== '0 || busy !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: kr=%b len=%0d ir=%b ov=%b od=%0d busy=%b err=%b, required all 0",
                  tag, key_ready, n_len, in_ready, out_valid, out_data, busy, err);
      end
   endtask

   task automatic load_keys(input logic [W-1:0] n, input logic [W-1:0] e, input logic [W-1:0] d);
      int lat;
      key_load = 1'b1;
      n_key = n; e_key = e; d_key = d;
      tick();
      key_load = 1'b0;
      k_n = n; k_e = e; k_d = d;
      n_checks++;
      if (key_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL key_ready_drop: got %b, required 0", key_ready);
      end
      lat = 1;
      while (key_ready !== 1'b1 && lat < 200) begin
         tick();
         lat++;
      end
      n_checks++;
      if (lat != W + 1) begin
         n_fail++;
         $display("FAIL key_latency: got %0d cycles, required %0d", lat, W + 1);
      end
      n_checks++;
      if (n_len !== LW'(bitlen(n))) begin
         n_fail++;
         $display("FAIL n_len: got %0d, required %0d", n_len, bitlen(n));
      end
   endtask

   task automatic send(input logic m, input logic [W-1:0] data, output bit accepted);
      mode     = m;
      in_data  = data;
      in_valid = 1'b1;
      accepted = in_ready;
      hs_cyc   = cyc;
      if (accepted && data < k_n && k_n >= 2)
         exp_q.push_back(modpow(data, m ? k_d : k_e, k_n));
      tick();
      in_valid = 1'b0;
   endtask

   task automatic recv(input int exp_lat, input int hold);
      int w;
      logic [W-1:0] held, expv;
      w = 0;
      while (out_valid !== 1'b1 && w < 3000) begin
         tick();
         w++;
      end
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL out_timeout: out_valid=%b after %0d cycles, required 1", out_valid, w);
         return;
      end
      n_checks++;
      if (cyc - hs_cyc != exp_lat || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL out_latency: got %0d busy=%b, required %0d busy=1", cyc - hs_cyc, busy, exp_lat);
      end
      held = out_data;
      for (int i = 0; i < hold; i++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure: ov=%b od=%0d ir=%b, required ov=1 od=%0d ir=0",
                     out_valid, out_data, in_ready, held);
         end
      end
      out_ready = 1'b1;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got out_data=%0d, required no output", out_data);
      end else begin
         expv = exp_q.pop_front();
         if (out_data !== expv) begin
            n_fail++;
            $display("FAIL out_data: got %0d, required %0d", out_data, expv);
         end
      end
      tick();
      out_ready = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL after_out: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic expect_no_output(input int cycles, input string tag);
      bit seen = 0;
      for (int i = 0; i < cycles; i++) begin
         if (out_valid === 1'b1) seen = 1;
         tick();
      end
      n_checks++;
      if (seen || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: out_valid seen=%b pending=%0d, required none", tag, seen, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      check_reset_outputs("reset_state");
      rst = 1'b0;
      tick();
   endtask

   task automatic test_key_load();
      load_keys(32'd3233, 32'd17, 32'd2753);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL in_ready_after_keys: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_encrypt();
      bit acc;
      send(1'b0, 32'd65, acc);
      recv(lat_for(k_e), 0);
   endtask

   task automatic test_decrypt_backpressure();
      bit acc;
      send(1'b1, 32'd2790, acc);
      recv(lat_for(k_d), 10);
   endtask

   task automatic test_reject();
      bit acc;
      send(1'b0, 32'd3233, acc);
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_pulse: got %b, required 1", err);
      end
      tick();
      n_checks++;
      if (err !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL err_after: err=%b in_ready=%b busy=%b, required 0/1/0", err, in_ready, busy);
      end
      expect_no_output(40, "reject_no_output");
   endtask

   task automatic test_zero_exp();
      bit acc;
      load_keys(32'd3233, 32'd0, 32'd2753);
      send(1'b0, 32'd5, acc);
      recv(2, 0);
      load_keys(32'd3233, 32'd17, 32'd2753);
   endtask

   task automatic test_reset_mid();
      bit acc;
      send(1'b0, 32'd65, acc);
      repeat (10) tick();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_mid: got %b, required 1", busy);
      end
      rst = 1'b1;
      tick();
      check_reset_outputs("reset_mid_mul");
      rst = 1'b0;
      exp_q.delete();
      load_keys(32'd3233, 32'd17, 32'd2753);
      send(1'b0, 32'd65, acc);
      recv(lat_for(k_e), 0);
   endtask

   task automatic test_key_load_busy();
      bit acc;
      send(1'b0, 32'd65, acc);
      repeat (20) tick();
      key_load = 1'b1;
      n_key = 32'd143; e_key = 32'd7; d_key = 32'd103;
      tick();
      key_load = 1'b0;
      recv(lat_for(k_e), 0);
      n_checks++;
      if (key_ready !== 1'b1 || n_len !== LW'(12)) begin
         n_fail++;
         $display("FAIL busy_key_ignored: key_ready=%b n_len=%0d, required 1/12", key_ready, n_len);
      end
   endtask

   task automatic test_same_cycle();
      int w;
      key_load = 1'b1;
      n_key = 32'd3233; e_key = 32'd17; d_key = 32'd2753;
      in_valid = 1'b1;
      in_data  = 32'd65;
      mode     = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL same_cycle_in_ready: got %b, required 0", in_ready);
      end
      tick();
      key_load = 1'b0;
      in_valid = 1'b0;
      w = 0;
      while (key_ready !== 1'b1 && w < 200) begin
         tick();
         w++;
      end
      expect_no_output(20, "same_cycle_no_output");
   endtask

   task automatic test_back_to_back();
      bit acc;
      logic [W-1:0] data_tab[4] = '{32'd1234, 32'd3000, 32'd2, 32'd0};
      logic         mode_tab[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         send(mode_tab[i], data_tab[i], acc);
         recv(lat_for(mode_tab[i] ? k_d : k_e), 0);
      end
      for (int i = 0; i < 3; i++) begin
         logic [W-1:0] v;
         v = 32'($urandom_range(1, 3232));
         send(1'(i % 2), v, acc);
         recv(lat_for((i % 2) ? k_d : k_e), i);
      end
   endtask

   initial begin
      rst = 1'b0; key_load = 1'b0; n_key = '0; e_key = '0; d_key = '0;
      mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      k_n = '0; k_e = '0; k_d = '0;
      test_reset();
      test_key_load();
      test_encrypt();
      test_decrypt_backpressure();
      test_reject();
      test_zero_exp();
      test_reset_mid();
      test_key_load_busy();
      test_same_cycle();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
